latch_bus_master: RTL and testbench

LATCH_BUS_MASTER -- requirements
Module: latch_bus_master

---
 rtl/latch_bus_master.sv | 189 ++++++++++++++++++
 tb/tb_latch_bus_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bus_master.sv
// latch_bus_master: sequences byte writes into, and readbacks from, four
// external transparent latches that share one D bus and one Q bus.
// A write drives BUS_D for a setup window, pulses the selected LE, then holds
// the data before releasing the driver. A read pulls the selected nOE low,
// waits for the bus to settle and samples BUS_Q.
//
// Optional feature: define LATCH_SHADOW_EN to keep a 4x8 shadow of written
// bytes and flag readbacks that disagree on MISMATCH. Without the macro
// MISMATCH is tied low and no shadow storage exists.
//
// DONE marks the final cycle of a transfer. A REQ presented in that cycle is
// accepted at its closing edge, so transfers can run back to back.
module latch_bus_master #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic       WR,
  input  logic [1:0] SEL,
  input  logic [7:0] WDATA,
  input  logic [7:0] BUS_Q,
  output logic       RDY,
  output logic       DONE,
  output logic [7:0] RDATA,
  output logic [7:0] BUS_D,
  output logic       BUS_DOE,
  output logic [3:0] LE,
  output logic [3:0] nOE,
  output logic       MISMATCH
);

  // Zero or negative timing parameters collapse to a single cycle.
  localparam int S_CYC = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
  localparam int P_CYC = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
  localparam int H_CYC = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;

  // Per-state counters stop at the last index and never wrap; 16 bits covers
  // any window up to 65536 cycles.
  localparam logic [15:0] S_LAST = 16'(S_CYC - 1);
  localparam logic [15:0] P_LAST = 16'(P_CYC - 1);
  localparam logic [15:0] H_LAST = 16'(H_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_SETTLE,
    R_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [1:0]  r_sel;
  logic        r_rdy;
  logic        r_done;
  logic [7:0]  r_rdata;
  logic [7:0]  r_bus_d;
  logic        r_bus_doe;
  logic [3:0]  r_le;
  logic [3:0]  r_noe;

  logic [3:0]  w_sel_oh;
  logic [3:0]  w_cur_oh;
  logic        w_last;
  logic        w_accept;

  assign w_sel_oh = 4'b0001 << SEL;
  assign w_cur_oh = 4'b0001 << r_sel;

  // Final cycle of a transfer: this is where DONE is high.
  assign w_last   = ((r_state == W_HOLD) && (r_cnt == H_LAST)) || (r_state == R_DONE);
  assign w_accept = REQ && ((r_state == IDLE) || w_last);

  // Transfer sequencer; every bus-facing output is registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sel     <= '0;
      r_rdy     <= 1'b1;
      r_done    <= 1'b0;
      r_rdata   <= '0;
      r_bus_d   <= '0;
      r_bus_doe <= 1'b0;
      r_le      <= '0;
      r_noe     <= 4'hF;
    end else begin
      // NOTE: state registers use non-blocking assignment so every update in
      // this block sees the pre-edge values, exactly like real flip-flops.
      r_done <= 1'b0;
      if (w_accept) begin
        r_sel <= SEL;
        r_cnt <= '0;
        r_rdy <= 1'b0;
        r_le  <= '0;
        if (WR) begin
          r_state   <= W_SETUP;
          r_bus_d   <= WDATA;
          r_bus_doe <= 1'b1;
          r_noe     <= 4'hF;
        end else begin
          r_state   <= R_SETTLE;
          r_bus_doe <= 1'b0;
          r_noe     <= ~w_sel_oh;
        end
      end else if (w_last) begin
        r_state   <= IDLE;
        r_rdy     <= 1'b1;
        r_bus_doe <= 1'b0;
        r_le      <= '0;
        r_noe     <= 4'hF;
      end else begin
        case (r_state)
          W_SETUP: begin
            if (r_cnt == S_LAST) begin
              r_state <= W_PULSE;
              r_cnt   <= '0;
              r_le    <= w_cur_oh;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          W_PULSE: begin
            if (r_cnt == P_LAST) begin
              r_state <= W_HOLD;
              r_cnt   <= '0;
              r_le    <= '0;
              r_done  <= (H_LAST == 16'd0);
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          W_HOLD: begin
            // Only non-final hold cycles reach here; flag DONE for the last.
            r_cnt  <= r_cnt + 16'd1;
            r_done <= ((r_cnt + 16'd1) == H_LAST);
          end
          R_SETTLE: begin
            if (r_cnt == S_LAST) begin
              r_state <= R_DONE;
              r_cnt   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
      // Sample the readback bus at the edge that closes R_DONE.
      if (r_state == R_DONE) r_rdata <= BUS_Q;
    end
  end

`ifdef LATCH_SHADOW_EN
  logic [7:0] r_shadow [4];
  logic       r_mismatch;

  // Shadow copy of committed writes and the readback comparison flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: this small array is reset on purpose so the first readback of a
      // never-written latch compares against a known zero, not X.
      for (int i = 0; i < 4; i++) r_shadow[i] <= 8'h00;
      r_mismatch <= 1'b0;
    end else begin
      if ((r_state == W_PULSE) && (r_cnt == P_LAST)) r_shadow[r_sel] <= r_bus_d;
      if (r_state == R_DONE) r_mismatch <= (BUS_Q != r_shadow[r_sel]);
    end
  end

  assign MISMATCH = r_mismatch;
`else
  assign MISMATCH = 1'b0;
`endif

  assign RDY     = r_rdy;
  assign DONE    = r_done;
  assign RDATA   = r_rdata;
  assign BUS_D   = r_bus_d;
  assign BUS_DOE = r_bus_doe;
  assign LE      = r_le;
  assign nOE     = r_noe;

endmodule

// File: tb/tb_latch_bus_master.sv
// Directed bench for latch_bus_master: a vector table of single transfers on
// a default-parameter instance, hand sequences for REQ holding, back-to-back
// transfers and mid-pulse reset, and a zero-parameter instance for clamping.
module tb_latch_bus_master;

`ifdef LATCH_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req, wr;
  logic [1:0] sel;
  logic [7:0] wdata, bus_q;
  logic       rdy, done, bus_doe, mismatch;
  logic [7:0] rdata, bus_d;
  logic [3:0] le, noe;

  logic       req0, wr0;
  logic [1:0] sel0;
  logic [7:0] wdata0, bus_q0;
  logic       rdy0, done0, bus_doe0, mismatch0;
  logic [7:0] rdata0, bus_d0;
  logic [3:0] le0, noe0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  latch_bus_master u_dut (
    .CLK(clk), .RST(rst), .REQ(req), .WR(wr), .SEL(sel), .WDATA(wdata),
    .BUS_Q(bus_q), .RDY(rdy), .DONE(done), .RDATA(rdata), .BUS_D(bus_d),
    .BUS_DOE(bus_doe), .LE(le), .nOE(noe), .MISMATCH(mismatch)
  );

  latch_bus_master #(.SETUP_CYC(0), .PULSE_CYC(0), .HOLD_CYC(0)) u_dut0 (
    .CLK(clk), .RST(rst), .REQ(req0), .WR(wr0), .SEL(sel0), .WDATA(wdata0),
    .BUS_Q(bus_q0), .RDY(rdy0), .DONE(done0), .RDATA(rdata0), .BUS_D(bus_d0),
    .BUS_DOE(bus_doe0), .LE(le0), .nOE(noe0), .MISMATCH(mismatch0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [1:0] sel;
    logic [7:0] wdata;
    logic [7:0] busq;
    int         exp_done;
    int         exp_le_first;
    int         exp_le_cnt;
    int         exp_doe;
    int         exp_noe;
    logic [7:0] exp_rdata;
    logic       exp_mm;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [1:0] s, input logic [7:0] d,
                              input logic [7:0] q, input logic [7:0] rd, input logic mm);
    vec_t v;
    v.wr = w; v.sel = s; v.wdata = d; v.busq = q;
    v.exp_done     = w ? 7 : 3;
    v.exp_le_first = w ? 3 : 0;
    v.exp_le_cnt   = w ? 3 : 0;
    v.exp_doe      = w ? 7 : 0;
    v.exp_noe      = w ? 0 : 3;
    v.exp_rdata    = rd;
    v.exp_mm       = mm;
    return v;
  endfunction

  // One transfer on the default instance, starting and ending at a negedge in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int done_at = 0, le_first = 0, le_cnt = 0, doe_cnt = 0, noe_cnt = 0, viol = 0;
    string tag;
    tag = $sformatf("v%0d", idx);
    req = 1'b1; wr = v.wr; sel = v.sel; wdata = v.wdata; bus_q = v.busq;
    @(negedge clk);
    req = 1'b0; wr = 1'b0; sel = 2'd0; wdata = 8'h00;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      if (le != 4'h0) begin
        if (le_first == 0) le_first = c;
        le_cnt++;
        if (le != (4'b0001 << v.sel)) viol++;
        if (!bus_doe) viol++;
      end
      if (bus_doe) begin
        doe_cnt++;
        if (bus_d !== v.wdata) viol++;
      end
      if (noe != 4'hF) begin
        noe_cnt++;
        if (noe != ~(4'b0001 << v.sel)) viol++;
        if (le != 4'h0) viol++;
      end
      if (rdy) viol++;
      if (done) done_at = c;
      @(negedge clk);
    end
    check({tag, "_done_cycle"}, done_at, v.exp_done);
    check({tag, "_le_first"}, le_first, v.exp_le_first);
    check({tag, "_le_cycles"}, le_cnt, v.exp_le_cnt);
    check({tag, "_doe_cycles"}, doe_cnt, v.exp_doe);
    check({tag, "_noe_cycles"}, noe_cnt, v.exp_noe);
    check({tag, "_bus_rules"}, viol, 0);
    check({tag, "_idle_after"}, {rdy, done, bus_doe, le, noe}, {1'b1, 1'b0, 1'b0, 4'h0, 4'hF});
    check({tag, "_rdata"}, rdata, v.exp_rdata);
    check({tag, "_mismatch"}, mismatch, v.exp_mm);
  endtask

  vec_t vecs [9];

  initial begin
    int n_done, first_done, d1, d2, le_cnt, le_first;

    vecs[0] = mk(1'b1, 2'd2, 8'hA5, 8'h00, 8'h00, 1'b0);
    vecs[1] = mk(1'b0, 2'd1, 8'h00, 8'h3C, 8'h3C, SH);
    vecs[2] = mk(1'b1, 2'd0, 8'h5A, 8'h00, 8'h3C, SH);
    vecs[3] = mk(1'b0, 2'd0, 8'h00, 8'h5B, 8'h5B, SH);
    vecs[4] = mk(1'b0, 2'd0, 8'h00, 8'h5A, 8'h5A, 1'b0);
    vecs[5] = mk(1'b1, 2'd3, 8'hFF, 8'h00, 8'h5A, 1'b0);
    vecs[6] = mk(1'b0, 2'd3, 8'h00, 8'hFF, 8'hFF, 1'b0);
    vecs[7] = mk(1'b0, 2'd2, 8'h00, 8'hA5, 8'hA5, 1'b0);
    vecs[8] = mk(1'b0, 2'd2, 8'h00, 8'h00, 8'h00, SH);

    rst = 1'b1; req = 1'b0; wr = 1'b0; sel = 2'd0; wdata = 8'h00; bus_q = 8'h00;
    req0 = 1'b0; wr0 = 1'b0; sel0 = 2'd0; wdata0 = 8'h00; bus_q0 = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {rdy, done, bus_doe, le, noe, bus_d, rdata, mismatch},
          {1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 8'h00, 8'h00, 1'b0});
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // REQ held through setup, pulse and hold (dropped in the DONE cycle): one transfer.
    req = 1'b1; wr = 1'b1; sel = 2'd1; wdata = 8'h11;
    n_done = 0; first_done = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      req = (c <= 6);
    end
    check("held_req_done_count", n_done, 1);
    check("held_req_done_cycle", first_done, 7);
    check("held_req_idle", {rdy, bus_doe}, {1'b1, 1'b0});

    // Back-to-back: a read requested in the write's DONE cycle starts at once.
    req = 1'b1; wr = 1'b1; sel = 2'd0; wdata = 8'h22;
    @(negedge clk);
    req = 1'b0;
    d1 = 0;
    for (int c = 1; c <= 20 && d1 == 0; c++) begin
      if (done) begin
        d1 = c;
        req = 1'b1; wr = 1'b0; sel = 2'd3; bus_q = 8'h77;
      end
      @(negedge clk);
    end
    req = 1'b0;
    check("b2b_write_done", d1, 7);
    check("b2b_read_started", {rdy, bus_doe, noe}, {1'b0, 1'b0, 4'b0111});
    d2 = 0;
    for (int c = d1 + 1; c <= d1 + 20 && d2 == 0; c++) begin
      if (done) d2 = c;
      @(negedge clk);
    end
    check("b2b_read_done", d2, 10);
    check("b2b_rdata", rdata, 8'h77);

    // Reset during W_PULSE aborts without DONE.
    req = 1'b1; wr = 1'b1; sel = 2'd2; wdata = 8'hC6;
    repeat (3) begin
      @(negedge clk);
      req = 1'b0;
    end
    check("abort_le_before", le, 4'b0100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {rdy, done, bus_doe, le, noe, rdata, mismatch},
          {1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 8'h00, 1'b0});
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || le != 4'h0) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Zero-parameter instance: clamped to one cycle per window.
    req0 = 1'b1; wr0 = 1'b1; sel0 = 2'd1; wdata0 = 8'hC3;
    @(negedge clk);
    req0 = 1'b0;
    d1 = 0; le_cnt = 0; le_first = 0;
    for (int c = 1; c <= 20 && d1 == 0; c++) begin
      if (le0 == 4'b0010) begin
        le_cnt++;
        if (le_first == 0) le_first = c;
      end
      if (c == 1) check("p0_write_bus", {bus_doe0, bus_d0}, {1'b1, 8'hC3});
      if (done0) d1 = c;
      @(negedge clk);
    end
    check("p0_write_done", d1, 3);
    check("p0_write_le", {le_first[7:0], le_cnt[7:0]}, {8'd2, 8'd1});
    req0 = 1'b1; wr0 = 1'b0; sel0 = 2'd2; bus_q0 = 8'h96;
    @(negedge clk);
    req0 = 1'b0;
    d2 = 0;
    for (int c = 1; c <= 20 && d2 == 0; c++) begin
      if (c == 1) check("p0_read_noe", noe0, 4'b1011);
      if (done0) d2 = c;
      @(negedge clk);
    end
    check("p0_read_done", d2, 2);
    check("p0_read_after", {rdy0, rdata0, mismatch0}, {1'b1, 8'h96, SH});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
